// File: rtl/layer_pkg.sv
// Shared widths, default weights/biases and FSM encoding
// for the fully-connected classifier layer.
package layer_pkg;

  localparam int FEAT_W = 12;
  localparam int W_W    = 8;
  localparam int B_W    = 16;
  localparam int PROD_W = 20;
  localparam int ACC_W  = 24;
  localparam int N_IN   = 3;
  localparam int N_OUT  = 2;

  // index o*3+i, LSB-first: rows {2,1,0} and {0,1,2}
  localparam logic [N_OUT*N_IN*W_W-1:0] FC_W = {
    8'd2, 8'd1, 8'd0,
    8'd0, 8'd1, 8'd2
  };

  localparam logic [N_OUT*B_W-1:0] FC_B = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } fc_state_e;

endpackage

// File: rtl/fc_mac.sv
// Registered signed 12x8 multiply-accumulate into 24 bits.
// load has priority over en; sum exposes the next value.
module fc_mac
  import layer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic signed [FEAT_W-1:0] a,
  input  logic signed [W_W-1:0]    b,
  output logic signed [ACC_W-1:0]  sum,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;

  assign prod = PROD_W'(a) * PROD_W'(b);
  assign sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= bias;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fc_classifier.sv
// Two-class fully-connected layer: one MAC per cycle over
// six weights, argmax on completion, 8-cycle cadence.
module fc_classifier
  import layer_pkg::*;
#(
  parameter logic [N_OUT*N_IN*W_W-1:0] W_FLAT = FC_W,
  parameter logic [N_OUT*B_W-1:0]      B_FLAT = FC_B
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [FEAT_W-1:0] in0,
  input  logic signed [FEAT_W-1:0] in1,
  input  logic signed [FEAT_W-1:0] in2,
  input  logic                     valid_in,
  output logic signed [ACC_W-1:0]  score0,
  output logic signed [ACC_W-1:0]  score1,
  output logic                     class_out,
  output logic                     valid_out,
  output logic                     busy,
  output logic                     overrun
);

  fc_state_e st;
  logic [2:0] k;

  logic signed [FEAT_W-1:0] f0, f1, f2;
  logic signed [ACC_W-1:0]  cand0;

  logic                     mac_load;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  mac_bias;
  logic signed [FEAT_W-1:0] mac_a;
  logic signed [W_W-1:0]    mac_b;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  mac_acc;

  logic signed [ACC_W-1:0]  b0, b1;

  assign b0 = ACC_W'($signed(B_FLAT[B_W-1:0]));
  assign b1 = ACC_W'($signed(B_FLAT[2*B_W-1:B_W]));

  logic start;
  logic mid;
  logic last;

  assign start = (st == ST_IDLE) && valid_in;
  assign mid   = (st == ST_MAC) && (k == 3'd2);
  assign last  = (st == ST_MAC) && (k == 3'd5);

  assign mac_load = start || mid;
  assign mac_en   = (st == ST_MAC);
  assign mac_bias = start ? b0 : b1;
  assign mac_b    = W_FLAT[W_W*k +: W_W];

  always_comb begin
    mac_a = f2;
    unique case (k)
      3'd0, 3'd3: mac_a = f0;
      3'd1, 3'd4: mac_a = f1;
      default:    mac_a = f2;
    endcase
  end

  fc_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mac_load),
    .en    (mac_en),
    .bias  (mac_bias),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum),
    .acc   (mac_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      k         <= '0;
      f0        <= '0;
      f1        <= '0;
      f2        <= '0;
      cand0     <= '0;
      score0    <= '0;
      score1    <= '0;
      class_out <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      overrun   <= valid_in && (st != ST_IDLE);
      unique case (st)
        ST_IDLE: begin
          if (valid_in) begin
            f0   <= in0;
            f1   <= in1;
            f2   <= in2;
            k    <= '0;
            busy <= 1'b1;
            st   <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (mid) cand0 <= mac_sum;
          if (last) begin
            st <= ST_DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        ST_DONE: begin
          score0    <= cand0;
          score1    <= mac_acc;
          class_out <= (mac_acc > cand0);
          valid_out <= 1'b1;
          busy      <= 1'b0;
          st        <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
// Directed bench for fc_classifier: latency, tie rule,
// extreme values, overrun, back-to-back and mid-run reset.
module tb_fc_classifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [11:0] in0 = '0, in1 = '0, in2 = '0;
  logic valid_in = 1'b0;

  logic signed [23:0] score0, score1, n_score0, n_score1;
  logic class_out, valid_out, busy, overrun;
  logic n_class, n_valid, n_busy, n_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_classifier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .valid_in  (valid_in),
    .score0    (score0),
    .score1    (score1),
    .class_out (class_out),
    .valid_out (valid_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  fc_classifier #(
    .W_FLAT ({6{8'h80}}),
    .B_FLAT ({2{16'h8000}})
  ) dut_neg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .valid_in  (valid_in),
    .score0    (n_score0),
    .score1    (n_score1),
    .class_out (n_class),
    .valid_out (n_valid),
    .busy      (n_busy),
    .overrun   (n_overrun)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a vector sampled at the next edge T; returns just after T
  task automatic send(input int a, input int b, input int c);
    in0 = 12'(a);
    in1 = 12'(b);
    in2 = 12'(c);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // from just after T: edges T+1..T+6 quiet, then T+7
  task automatic wait_done(input string tag);
    int early;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out) early++;
    end
    chk({tag, "_early_valid"}, early, 0);
    tick();
    chk({tag, "_valid"}, valid_out, 1);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int seen;
    tick();
    chk("rst_score0", score0, 0);
    chk("rst_score1", score1, 0);
    chk("rst_class", class_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    send(10, 20, 30);
    chk("v1_busy", busy, 1);
    wait_done("v1");
    chk("v1_score0", score0, 40);
    chk("v1_score1", score1, 80);
    chk("v1_class", class_out, 1);
    tick();
    chk("v1_valid_drop", valid_out, 0);
    chk("v1_hold_s1", score1, 80);

    send(10, 20, 10);
    wait_done("tie");
    chk("tie_score0", score0, 40);
    chk("tie_score1", score1, 40);
    chk("tie_class", class_out, 0);

    send(2047, 2047, 2047);
    wait_done("neg");
    chk("neg_valid", n_valid, 1);
    chk("neg_score0", n_score0, -818816);
    chk("neg_score1", n_score1, -818816);
    chk("neg_class", n_class, 0);
    tick();

    send(10, 20, 30);
    tick();
    tick();
    in0 = 12'sd99;
    in1 = 12'sd99;
    in2 = 12'sd99;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("ovr_pulse", overrun, 1);
    tick();
    chk("ovr_drop", overrun, 0);
    chk("ovr_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("ovr_valid", valid_out, 1);
    chk("ovr_score0", score0, 40);
    chk("ovr_score1", score1, 80);
    send(10, 20, 10);
    chk("b2b_busy", busy, 1);
    chk("b2b_valid_drop", valid_out, 0);
    wait_done("b2b");
    chk("b2b_score0", score0, 40);
    chk("b2b_score1", score1, 40);
    chk("b2b_class", class_out, 0);
    tick();

    send(10, 20, 30);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_score0", score0, 0);
    chk("mrst_score1", score1, 0);
    chk("mrst_class", class_out, 0);
    chk("mrst_valid", valid_out, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out || busy) seen++;
    end
    chk("mrst_no_valid", seen, 0);

    send(1, 2, 3);
    wait_done("post");
    chk("post_score0", score0, 4);
    chk("post_score1", score1, 8);
    chk("post_class", class_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
